// File: rtl/instruction_queue_pkg.sv
// Shared constants and the queue entry layout for the fetch-to-decode instruction queue.
package instruction_queue_pkg;

  localparam int   IQ_DEPTH_DEF = 16;
  localparam int   INST_W       = 32;
  localparam logic TRUE         = 1'b1;
  localparam logic FALSE        = 1'b0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc;
    logic              pred_jump;
  } iq_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// Circular instruction queue between fetch and decode; IQ_BYPASS_EN enables the empty-queue bypass.
// Latency: 2 cycles push-to-issue (1 cycle when bypassing an empty queue).
// Backpressure: iq_full_out stops fetch; issue_ready_in low holds entries; rdy_in low freezes everything.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int PTR_W    = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic              if_valid,
  input  logic [INST_W-1:0] if_inst,
  input  logic [INST_W-1:0] if_pc,
  input  logic              if_pred_jump,
  input  logic              issue_ready_in,
  output logic              iq_full_out,
  output logic              issue_valid,
  output logic [INST_W-1:0] issue_inst,
  output logic [INST_W-1:0] issue_pc,
  output logic              issue_pred_jump
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(IQ_DEPTH);

  iq_entry_t        mem_q [IQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             issue_valid_q, issue_valid_d;
  iq_entry_t        issue_q, issue_d;
  iq_entry_t        in_entry;
  logic             wr_en;
  logic             push_ok;
  logic             pop_ok;
  logic             bypass;

  assign in_entry    = '{inst: if_inst, pc: if_pc, pred_jump: if_pred_jump};
  assign iq_full_out = (count_q == FULL_CNT);
  // Full test uses the pre-edge count, so a pop never makes room for a same-cycle push.
  assign push_ok     = if_valid && !iq_full_out;
  assign pop_ok      = (count_q != '0) && issue_ready_in;

`ifdef IQ_BYPASS_EN
  assign bypass = (count_q == '0) && if_valid && issue_ready_in;
`else
  assign bypass = FALSE;
`endif

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    issue_valid_d = issue_valid_q;
    issue_d       = issue_q;
    wr_en         = FALSE;
    if (rdy_in) begin
      issue_valid_d = FALSE;
      if (roll_back) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else if (bypass) begin
        issue_d       = in_entry;
        issue_valid_d = TRUE;
      end else begin
        if (push_ok) begin
          wr_en  = TRUE;
          tail_d = tail_q + 1'b1;
        end
        if (pop_ok) begin
          issue_d       = mem_q[head_q];
          issue_valid_d = TRUE;
          head_d        = head_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
          count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= FALSE;
      issue_q       <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en && rst_in) begin
      mem_q[tail_q] <= in_entry;
    end
  end

  assign issue_valid     = issue_valid_q;
  assign issue_inst      = issue_q.inst;
  assign issue_pc        = issue_q.pc;
  assign issue_pred_jump = issue_q.pred_jump;

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: directed pushes queue expected issues, a monitor checks them.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, if_valid, if_pred_jump, issue_ready_in;
  logic [31:0] if_inst, if_pc;
  logic        iq_full_out, issue_valid, issue_pred_jump;
  logic [31:0] issue_inst, issue_pc;

  always #5 clk_in = ~clk_in;

  instruction_queue #(.IQ_DEPTH(16), .PTR_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pred_jump(if_pred_jump),
    .issue_ready_in(issue_ready_in), .iq_full_out(iq_full_out), .issue_valid(issue_valid),
    .issue_inst(issue_inst), .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump)
  );

  iq_entry_t exp_q[$];
  int        n_tests = 0;
  int        n_fail  = 0;
  bit        mon_en  = 1'b0;

  function automatic iq_entry_t mk(input logic [31:0] pc);
    iq_entry_t e;
    e.inst      = {~pc[15:0], pc[15:0]};
    e.pc        = pc;
    e.pred_jump = pc[2];
    return e;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input bit will_issue);
    iq_entry_t e;
    e            = mk(pc);
    if_valid     = 1'b1;
    if_inst      = e.inst;
    if_pc        = e.pc;
    if_pred_jump = e.pred_jump;
    if (will_issue) exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    if_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk_in);
      k++;
    end
    repeat (3) @(posedge clk_in);
    #1;
    check(name, 65'(exp_q.size()), 65'd0);
  endtask

  function automatic logic [64:0] outs();
    return {issue_inst, issue_pc, issue_pred_jump};
  endfunction

  initial begin
    fork
      forever begin
        @(negedge clk_in);
        if (mon_en && issue_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_issue: got pc %h, required no issue", issue_pc);
          end else begin
            iq_entry_t e;
            e = exp_q.pop_front();
            check("issue_order", outs(), 65'(e));
          end
        end
      end
    join_none

    // Reset must win over rdy_in low and roll_back high.
    rst_in = 1'b0; rdy_in = 1'b0; roll_back = 1'b1; issue_ready_in = 1'b1;
    if_valid = 1'b1; if_inst = '1; if_pc = '1; if_pred_jump = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_valid", 65'(issue_valid), 65'd0);
    check("reset_outs", outs(), 65'd0);
    check("reset_full", 65'(iq_full_out), 65'd0);
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; if_valid = 1'b0;
    mon_en = 1'b1;
    @(posedge clk_in);
    #1;

    // Three pushes stream out in order; first issue two edges after first push.
    issue_ready_in = 1'b1;
    push(32'h0, 1'b1);
    check("t1_lat_edge_n", 65'(issue_valid), 65'(BYP));
    push(32'h4, 1'b1);
    check("t1_lat_edge_n1", 65'(issue_valid), 65'd1);
    push(32'h8, 1'b1);
    drain("t1_drain");

    // Fill to 16, 17th push dropped.
    issue_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(32'(i * 4), 1'b1);
      if (i == 14) check("t2_not_full_15", 65'(iq_full_out), 65'd0);
    end
    check("t2_full_16", 65'(iq_full_out), 65'd1);
    push(32'h40, 1'b0);
    check("t2_full_after_drop", 65'(iq_full_out), 65'd1);
    issue_ready_in = 1'b1;
    drain("t2_drain");

    // Full queue with push+pop every cycle: only the first push is dropped, pointers wrap.
    issue_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) push(32'h200 + 32'(i * 4), 1'b1);
    issue_ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(32'h280 + 32'(i * 4), i != 0);
      if (i == 0) check("t3_not_full_after_pop", 65'(iq_full_out), 65'd0);
    end
    check("t3_count_held_15", 65'(iq_full_out), 65'd0);
    drain("t3_drain");

    // Roll back a 5-entry queue with a simultaneous push and pop request.
    issue_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h300 + 32'(i * 4), 1'b0);
    roll_back = 1'b1;
    issue_ready_in = 1'b1;
    push(32'h3f0, 1'b0);
    roll_back = 1'b0;
    check("t4_valid_after_rb", 65'(issue_valid), 65'd0);
    check("t4_full_after_rb", 65'(iq_full_out), 65'd0);
    repeat (5) @(posedge clk_in);
    #1;
    issue_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(32'h400 + 32'(i * 4), 1'b1);
      if (i == 14) check("t4_not_full_15", 65'(iq_full_out), 65'd0);
    end
    check("t4_full_16", 65'(iq_full_out), 65'd1);
    issue_ready_in = 1'b1;
    drain("t4_drain");

    // Freeze for 3 cycles mid-stream, with roll_back asserted and ignored.
    issue_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(i * 4), 1'b1);
    issue_ready_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    rdy_in = 1'b0; mon_en = 1'b0; roll_back = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      check("t5_hold_valid", 65'(issue_valid), 65'd1);
      check("t5_hold_data", outs(), 65'(mk(32'h504)));
    end
    check("t5_pending", 65'(exp_q.size()), 65'd4);
    roll_back = 1'b0;
    rdy_in = 1'b1;
    @(posedge clk_in);
    #1;
    mon_en = 1'b1;
    drain("t5_drain");

    // Reset mid-stream discards the queue.
    issue_ready_in = 1'b1;
    push(32'h600, 1'b1);
    push(32'h604, 1'b1);
    push(32'h608, BYP);
    @(negedge clk_in);
    #1;
    rst_in = 1'b0;
    if_valid = 1'b1; if_pc = 32'h60c; if_inst = 32'h1234_5678; if_pred_jump = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1; if_valid = 1'b0;
    check("t6_rst_valid", 65'(issue_valid), 65'd0);
    check("t6_rst_outs", outs(), 65'd0);
    check("t6_rst_full", 65'(iq_full_out), 65'd0);
    repeat (4) @(posedge clk_in);
    #1;
    push(32'h700, 1'b1);
    check("t6_lat_after_rst", 65'(issue_valid), 65'(BYP));
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
